// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_D    = 2'd2,
        ARB_RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    // Wide all-ones constant; the top slices it down to its byte-enable width.
    localparam int                  MAX_BE_W     = 64;
    localparam logic [MAX_BE_W-1:0] FETCH_BE_ALL = '1;

    // Watchdog counter is at least 8 bits, wider if the limit needs it.
    localparam int MIN_TMO_CNT_W = 8;

    function automatic int tmo_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < MIN_TMO_CNT_W) ? MIN_TMO_CNT_W : w;
    endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Two-way chooser: data wins contention unless data took the previous grant.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       d_req,
    input  logic       last_d,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

    // Fetch only loses a tie when data did not win the previous grant.
    always_comb begin
        grant_valid = if_req | d_req;
        grant_owner = OWN_IF;
        if (d_req && !(if_req && last_d)) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the fetch port and the data port.
// Each grant is latched and run as a req/ack transfer, then the owner's ready
// pulses for one cycle. Define MEMARB_TIMEOUT_EN to add a watchdog on mem_ack
// that aborts a hung transfer and reports it on arb_err.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                if_stall,
    output logic                d_stall,
    output logic                arb_err
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state, state_n;
    arb_owner_t owner;
    arb_owner_t grant_owner;
    logic       grant_valid;
    logic       last_d;
    logic       grant;
    logic       capture;
    logic       abort;
    logic       busy;
    logic       tmo_hit;

    // Address bits below word granularity are not used by fetch.
    logic unused_if_addr_lsbs;
    assign unused_if_addr_lsbs = ^if_addr[1:0];

    mem_arb_picker u_picker (
        .if_req      (if_req),
        .d_req       (d_req),
        .last_d      (last_d),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    assign busy     = (state == ARB_IF) || (state == ARB_D);
    assign mem_req  = busy;
    assign if_ready = (state == ARB_RESP) && (owner == OWN_IF);
    assign d_ready  = (state == ARB_RESP) && (owner == OWN_D);
    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;

    // State register; async reset drops mem_req at once, abandoning the transfer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle strobes: grant in IDLE, capture/abort while busy.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (grant_valid) begin
                    grant   = 1'b1;
                    state_n = (grant_owner == OWN_D) ? ARB_D : ARB_IF;
                end
            end
            ARB_IF, ARB_D: begin
                if (mem_ack) begin
                    capture = 1'b1;
                    state_n = ARB_RESP;
                end else if (tmo_hit) begin
                    abort   = 1'b1;
                    state_n = ARB_RESP;
                end
            end
            ARB_RESP: state_n = ARB_IDLE;
            default:  state_n = ARB_IDLE;
        endcase
    end

    // Latch the winner's command so the bus stays stable even if the port flushes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            owner     <= OWN_IF;
            last_d    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (grant) begin
            owner  <= grant_owner;
            last_d <= (grant_owner == OWN_D);
            if (grant_owner == OWN_D) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= '0;
                mem_be    <= FETCH_BE_ALL[BE_W-1:0];
            end
        end
    end

    // Per-port read data; holds until the next completion for the same port.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (capture || abort) begin
            if (owner == OWN_D) begin
                d_rdata <= capture ? mem_rdata : '0;
            end else begin
                if_rdata <= capture ? mem_rdata : '0;
            end
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    localparam int CNT_W = tmo_cnt_w(TIMEOUT_CYC);

    logic [CNT_W-1:0] wd_cnt;
    logic             timed_out;

    // Hit on the cycle that would be the TIMEOUT_CYC-th busy cycle without ack.
    assign tmo_hit = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign arb_err = (state == ARB_RESP) && timed_out;

    // Watchdog counts busy cycles without ack, restarting on every grant.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt <= '0;
        end else if (grant) begin
            wd_cnt <= '0;
        end else if (busy && !mem_ack) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

    // Remember an abort so arb_err pulses alongside the owner's ready.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timed_out <= 1'b0;
        end else if (grant) begin
            timed_out <= 1'b0;
        end else if (abort) begin
            timed_out <= 1'b1;
        end
    end
`else
    // Without the watchdog a busy transfer waits for mem_ack indefinitely.
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign tmo_hit = 1'b0;
    assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: table-driven single transactions plus sequences for
// contention, mid-transfer reset, flush and (with MEMARB_TIMEOUT_EN) the watchdog.
module tb_mem_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = DW / 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          if_stall;
    logic          d_stall;
    logic          arb_err;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .n_rst(n_rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .if_stall(if_stall), .d_stall(d_stall), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        bit          err;
        int          busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    function automatic exp_t mk_exp(input bit is_d, input bit we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    input logic [31:0] rdata, input bit err, input int busy);
        exp_t e;
        e.is_d = is_d; e.we = we; e.addr = addr; e.wdata = wdata;
        e.be = be; e.rdata = rdata; e.err = err; e.busy = busy;
        return e;
    endfunction

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // ---------------- memory model ----------------
    int          mem_wait = 0;
    bit          fixed_en = 1'b0;
    logic [31:0] mem_fixed = '0;
    int          busy_cnt = 0;
    int          last_busy = 0;
    int          n_grants = 0;
    bit          bus_stable = 1'b1;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    // Acks on the (mem_wait+1)-th cycle of mem_req; records and watches bus fields.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            busy_cnt++;
            last_busy = busy_cnt;
            if (busy_cnt == 1) begin
                n_grants++;
                cap_we = mem_we; cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be;
                bus_stable = 1'b1;
            end else if ({mem_we, mem_addr, mem_wdata, mem_be} !== {cap_we, cap_addr, cap_wdata, cap_be}) begin
                bus_stable = 1'b0;
            end
            mem_ack   = (busy_cnt == mem_wait + 1);
            mem_rdata = fixed_en ? mem_fixed : mem_fn(mem_addr);
        end else begin
            busy_cnt  = 0;
            mem_ack   = 1'b0;
            mem_rdata = 32'hBAD0_0BAD;
        end
    end

    // Completion monitor: pops the oldest expectation on every ready pulse.
    always @(negedge clk) begin
        if (n_rst && (if_ready || d_ready)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ready: if_ready=%0b d_ready=%0b with empty scoreboard", if_ready, d_ready);
            end else begin
                mon_e = exp_q.pop_front();
                chk("owner", {31'd0, d_ready}, {31'd0, mon_e.is_d});
                chk("single_ready", {31'd0, if_ready & d_ready}, 32'd0);
                if (!(mon_e.is_d && mon_e.we))
                    chk("rdata", mon_e.is_d ? d_rdata : if_rdata, mon_e.rdata);
                chk("bus_addr", cap_addr, mon_e.addr);
                chk("bus_we", {31'd0, cap_we}, {31'd0, mon_e.we});
                chk("bus_be", {28'd0, cap_be}, {28'd0, mon_e.be});
                if (mon_e.is_d && mon_e.we)
                    chk("bus_wdata", cap_wdata, mon_e.wdata);
                chk("bus_stable", {31'd0, bus_stable}, 32'd1);
                chk("busy_cycles", last_busy, mon_e.busy);
                chk("arb_err", {31'd0, arb_err}, {31'd0, mon_e.err});
            end
        end
        if (n_rst && arb_err && !(if_ready || d_ready))
            chk("arb_err_stray", {31'd0, arb_err}, 32'd0);
    end

    // ---------------- table-driven transactions ----------------
    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          wait_c;
        logic [31:0] mem_val;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        bit          exp_we;
        int          exp_lat;
    } vec_t;

    task automatic do_txn(input int idx, input vec_t v);
        int   cyc;
        bit   done;
        bit   stall_ok;
        logic rdy;
        logic stl;
        @(negedge clk);
        mem_wait  = v.wait_c;
        fixed_en  = 1'b1;
        mem_fixed = v.mem_val;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        exp_q.push_back(mk_exp(v.is_d, v.exp_we, v.exp_addr, v.wdata, v.exp_be,
                               v.mem_val, 1'b0, v.wait_c + 1));
        cyc = 0; done = 1'b0; stall_ok = 1'b1;
        while (!done && cyc < 50) begin
            #1;
            rdy = v.is_d ? d_ready : if_ready;
            stl = v.is_d ? d_stall : if_stall;
            if (rdy === 1'b1) begin
                done = 1'b1;
                chk($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
                if (stl !== 1'b0) stall_ok = 1'b0;
                if_req = 1'b0;
                d_req  = 1'b0;
            end else begin
                if (stl !== 1'b1) stall_ok = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("v%0d_done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d_stall", idx), {31'd0, stall_ok}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // Waits (bounded) for a port's ready, sampling just after each negedge.
    task automatic wait_ready(input bit is_d, input int limit, output int cyc, output bit seen);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < limit) begin
            #1;
            if ((is_d ? d_ready : if_ready) === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    vec_t vecs[5];

    initial begin
        int       cyc;
        int       cnt;
        int       n0;
        bit       seen;
        logic [2:0] ord;

        n_rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        vecs[0] = '{is_d:1'b0, we:1'b0, addr:32'h1000_0006, wdata:32'h0, be:4'h0, wait_c:1,
                    mem_val:32'h0000_0033, exp_addr:32'h1000_0004, exp_be:4'hF, exp_we:1'b0, exp_lat:3};
        vecs[1] = '{is_d:1'b1, we:1'b1, addr:32'h2000_0008, wdata:32'hDEAD_BEEF, be:4'b0011, wait_c:4,
                    mem_val:32'h1234_5678, exp_addr:32'h2000_0008, exp_be:4'b0011, exp_we:1'b1, exp_lat:6};
        vecs[2] = '{is_d:1'b1, we:1'b0, addr:32'h2000_0014, wdata:32'h0, be:4'hF, wait_c:0,
                    mem_val:32'hCAFE_F00D, exp_addr:32'h2000_0014, exp_be:4'hF, exp_we:1'b0, exp_lat:2};
        vecs[3] = '{is_d:1'b0, we:1'b0, addr:32'h0000_0FFF, wdata:32'h0, be:4'h0, wait_c:2,
                    mem_val:32'hFFFF_FFFF, exp_addr:32'h0000_0FFC, exp_be:4'hF, exp_we:1'b0, exp_lat:4};
        vecs[4] = '{is_d:1'b1, we:1'b0, addr:32'hFFFF_FFFC, wdata:32'h5555_AAAA, be:4'b1000, wait_c:0,
                    mem_val:32'h0000_0000, exp_addr:32'hFFFF_FFFC, exp_be:4'b1000, exp_we:1'b0, exp_lat:2};

        // Reset values
        #2;
        chk("rst_mem_req",   {31'd0, mem_req},  32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},   32'd0);
        chk("rst_mem_addr",  mem_addr,          32'd0);
        chk("rst_mem_wdata", mem_wdata,         32'd0);
        chk("rst_mem_be",    {28'd0, mem_be},   32'd0);
        chk("rst_if_ready",  {31'd0, if_ready}, 32'd0);
        chk("rst_d_ready",   {31'd0, d_ready},  32'd0);
        chk("rst_if_rdata",  if_rdata,          32'd0);
        chk("rst_d_rdata",   d_rdata,           32'd0);
        chk("rst_arb_err",   {31'd0, arb_err},  32'd0);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        // Single-port transactions
        for (int i = 0; i < 5; i++) do_txn(i, vecs[i]);
        chk("if_rdata_hold", if_rdata, 32'hFFFF_FFFF);

        // Contention from reset: D, IF, D with both requests held throughout
        do_reset();
        @(negedge clk);
        mem_wait = 0; fixed_en = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000_0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0010; d_be = 4'hF; d_wdata = '0;
        exp_q.push_back(mk_exp(1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'hF, mem_fn(32'h2000_0010), 1'b0, 1));
        exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h1000_0100, 32'h0, 4'hF, mem_fn(32'h1000_0100), 1'b0, 1));
        exp_q.push_back(mk_exp(1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'hF, mem_fn(32'h2000_0010), 1'b0, 1));
        cnt = 0; cyc = 0; ord = '0;
        while (cnt < 3 && cyc < 100) begin
            #1;
            if (if_ready || d_ready) begin
                ord = {ord[1:0], d_ready};
                if (cnt == 0) chk("d_stall_at_first_resp", {31'd0, d_stall}, 32'd0);
                cnt++;
                if (cnt == 3) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
            if (cnt < 3) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("contention_count", cnt, 3);
        chk("contention_order", {29'd0, ord}, 32'd5);

        // Reset in the middle of a hung store; pending fetch is granted afterwards
        @(negedge clk);
        mem_wait = 1000;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000_0020; d_wdata = 32'h1111_2222; d_be = 4'hF;
        cyc = 0;
        #1;
        while (mem_req !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("rst_mid_mem_req_before", {31'd0, mem_req}, 32'd1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_mid_if_ready", {31'd0, if_ready}, 32'd0);
        d_req = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000_0300;
        mem_wait = 1;
        exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h1000_0300, 32'h0, 4'hF, mem_fn(32'h1000_0300), 1'b0, 2));
        @(negedge clk);
        n_rst = 1'b1;
        wait_ready(1'b0, 30, cyc, seen);
        if_req = 1'b0;
        chk("rst_mid_if_seen", {31'd0, seen}, 32'd1);
        chk("rst_mid_if_latency", cyc, 3);

        // Fetch flushed while the data transfer is in flight: one grant only
        @(negedge clk);
        mem_wait = 2;
        n0 = n_grants;
        if_req = 1'b1; if_addr = 32'h1000_0400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0040; d_be = 4'hF;
        exp_q.push_back(mk_exp(1'b1, 1'b0, 32'h2000_0040, 32'h0, 4'hF, mem_fn(32'h2000_0040), 1'b0, 3));
        cyc = 0;
        #1;
        while (mem_req !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if_req = 1'b0;
        wait_ready(1'b1, 30, cyc, seen);
        d_req = 1'b0;
        chk("flush_d_seen", {31'd0, seen}, 32'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("flush_grants", n_grants - n0, 1);
        chk("flush_mem_req_idle", {31'd0, mem_req}, 32'd0);

`ifdef MEMARB_TIMEOUT_EN
        // Memory never acks: abort after TMO busy cycles with arb_err and zero data
        @(negedge clk);
        mem_wait = 1000;
        if_req = 1'b1; if_addr = 32'h1000_0500;
        exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h1000_0500, 32'h0, 4'hF, 32'h0, 1'b1, TMO));
        wait_ready(1'b0, 40, cyc, seen);
        chk("tmo_seen", {31'd0, seen}, 32'd1);
        chk("tmo_arb_err", {31'd0, arb_err}, 32'd1);
        chk("tmo_mem_req", {31'd0, mem_req}, 32'd0);
        if_req = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between the pipeline's instruction-fetch port and its data (load/store) port.
- When both ports contend, data accesses win, with alternation to prevent fetch starvation.
- Each transaction is sequenced through a request/ack handshake to the memory, which may have multi-cycle latency.
- Combinational stall outputs feed the hazard unit, which holds the affected pipeline stages (StallF/StallD/StallE-level hold) while a port waits.

Parameters:
- ADDR_W, 32, address width of both ports and the memory bus.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYC, 255, watchdog limit in cycles waiting for mem_ack. Used only with MEMARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  ADDR_W  fetch address; bits [1:0] are ignored.
- if_rdata  out  DATA_W  fetched word; registered, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data; registered, valid while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for data.
- mem_req  out  1  bus request; held until mem_ack.
- mem_we  out  1  bus write strobe.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  DATA_W  bus write data.
- mem_be  out  DATA_W/8  bus byte enables.
- mem_rdata  in  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle transfer completion from memory.
- if_stall  out  1  if_req & ~if_ready (combinational).
- d_stall  out  1  d_req & ~d_ready (combinational).
- arb_err  out  1  timeout pulse. Tied 0 without MEMARB_TIMEOUT_EN.

Behaviour:
- State machine: ARB_IDLE, ARB_IF, ARB_D, ARB_RESP.
- Reset values: state=ARB_IDLE; all outputs 0; last_d=0; rdata regs=0.
- Reset is asynchronous and may arrive mid-transaction. mem_req drops immediately and the transfer is abandoned; the memory slave must tolerate this.
- ARB_IDLE arbitration:
  - Only d_req set: go to ARB_D.
  - Only if_req set: go to ARB_IF.
  - Both set: if last_d=1, fetch wins; otherwise data wins.
- last_d update: on every grant, last_d <= (grant==data). This alternates under permanent contention, D first.
- On grant, the winner's command is latched into internal registers. The mem_* outputs drive from these latches, so mem_req rises the cycle after the request is seen.
- Fetch grant: mem_we=0, mem_be=all ones, mem_addr = {if_addr[ADDR_W-1:2],2'b00}.
- Data grant: mem_we=d_we, mem_be=d_be, mem_addr=d_addr, mem_wdata=d_wdata.
- ARB_IF/ARB_D: mem_req=1, held stable until mem_ack. On mem_ack, capture mem_rdata into the winner's rdata reg and go to ARB_RESP. mem_ack while in ARB_IDLE is ignored.
- ARB_RESP: pulse the owner's ready for exactly 1 cycle; mem_req=0; next state ARB_IDLE.
- Stores also receive d_ready. d_rdata for a store is don't-care but is still captured.
- Minimum latency, request to ready: 3 cycles with a 1-cycle-ack memory (IDLE, BUSY+ack, RESP).
- A requester sampling ready=1 considers its transaction complete. req high in the following cycle is a new transaction.
- if_rdata/d_rdata hold their value until the next capture for the same port.
- The losing port's req stays pending and is served at the next ARB_IDLE. A port's req dropping while waiting (flush) before grant is legal. After grant, the transaction completes regardless.

Optional Feature:
- Macro: MEMARB_TIMEOUT_EN.
- With the macro:
  - An 8+ bit counter clears on grant and increments each BUSY cycle without mem_ack.
  - On reaching TIMEOUT_CYC: abort (mem_req=0), load rdata reg with 0, go to ARB_RESP, pulse arb_err together with the owner's ready.
- Without the macro: no counter; arb_err tied 0; BUSY waits indefinitely.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_IF, ARB_D, ARB_RESP}.
  - typedef enum arb_owner_t {OWN_IF, OWN_D}.
  - localparam FETCH_BE_ALL.
- One sub-module: mem_arb_picker. Combinational 2-way priority/alternation chooser taking if_req, d_req, last_d; outputs grant_valid, grant_owner.

Test Plan:
- Fetch only, if_addr=0x1000_0006, mem_ack 1 cycle after mem_req, mem_rdata=0x0000_0033 -> mem_addr=0x1000_0004, mem_be=4'hF, mem_we=0; if_ready pulse with if_rdata=0x33 at cycle 3; if_stall=1 for cycles 0-2.
- Simultaneous if_req and d_req (load 0x2000_0010) held 3 transactions, last_d=0 -> grant order D, IF, D; d_stall deasserts after first RESP.
- Store d_addr=0x2000_0008, d_be=4'b0011, d_wdata=0xDEAD_BEEF, memory acks after 4 wait cycles -> mem_req held 5 cycles with stable bus fields; mem_we=1; d_ready pulses exactly once.
- Assert n_rst=0 during ARB_D with mem_req=1 -> mem_req, ready and stall-related state at 0 immediately; after release, state ARB_IDLE and a pending if_req is granted next.
- if_req dropped in the cycle before its grant while d_req is pending -> only the data transaction is issued.
- With MEMARB_TIMEOUT_EN, TIMEOUT_CYC=8, mem_ack never asserted -> after 8 BUSY cycles mem_req=0; if_ready and arb_err pulse together; if_rdata=0.
